// File: rtl/msend_arbiter.sv
// Round-robin arbiter feeding one 24-bit serializer from four request channels.
// Each transfer runs IDLE -> START -> WAIT_DONE -> GAP, then back to IDLE.
module msend_arbiter #(
  parameter int NCH     = 4,
  parameter int GAP_CYC = 8,
  parameter int TMO_CYC = 1023
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   unit_en,
  input  logic [NCH-1:0]         req,
  input  logic [24*NCH-1:0]      req_data,
  output logic [NCH-1:0]         ack,
  output logic [NCH-1:0]         err,
  output logic                   send_start,
  output logic [23:0]            send_data,
  input  logic                   sending,
  input  logic                   send_done,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] grant_ch
);

  localparam int CW = $clog2(NCH);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t         state;
  logic [15:0]    tmo_cnt;
  logic [7:0]     gap_cnt;
  logic [CW-1:0]  last_grant;
  logic [CW-1:0]  win;
  logic [CW-1:0]  idx;
  logic           win_vld;
  logic [NCH-1:0] gnt_oh;
  logic           unused_sending;

  assign unused_sending = sending;
  assign busy   = (state != IDLE);
  assign gnt_oh = NCH'(1) << grant_ch;

  // Search begins just after the previous winner and wraps.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = last_grant + CW'(i + 1);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      ack        <= '0;
      err        <= '0;
      send_start <= 1'b0;
      send_data  <= '0;
      grant_ch   <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      ack        <= '0;
      err        <= '0;
      send_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (unit_en && win_vld) begin
            grant_ch   <= win;
            last_grant <= win;
            send_data  <= req_data[int'(win)*24 +: 24];
            send_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // A done arriving on the timeout cycle wins.
          if (send_done) begin
            ack     <= gnt_oh;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            ack     <= gnt_oh;
            err     <= gnt_oh;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msend_arbiter.sv
// Directed bench for msend_arbiter: dut uses default timeout, dut_t a 16-cycle
// timeout; both share stimulus and are reset between scenarios.
module tb_msend_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        unit_en = 1'b0;
  logic [3:0]  req = '0;
  logic [95:0] req_data = '0;
  logic        sending = 1'b0;
  logic        send_done = 1'b0;

  logic [3:0]  ack, err, t_ack, t_err;
  logic        send_start, busy, t_send_start, t_busy;
  logic [23:0] send_data, t_send_data;
  logic [1:0]  grant_ch, t_grant_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msend_arbiter #(.NCH(4), .GAP_CYC(8), .TMO_CYC(1023)) dut (
    .clk(clk), .rstn(rstn), .unit_en(unit_en), .req(req),
    .req_data(req_data), .ack(ack), .err(err),
    .send_start(send_start), .send_data(send_data),
    .sending(sending), .send_done(send_done),
    .busy(busy), .grant_ch(grant_ch)
  );

  msend_arbiter #(.NCH(4), .GAP_CYC(8), .TMO_CYC(16)) dut_t (
    .clk(clk), .rstn(rstn), .unit_en(unit_en), .req(req),
    .req_data(req_data), .ack(t_ack), .err(t_err),
    .send_start(t_send_start), .send_data(t_send_data),
    .sending(sending), .send_done(send_done),
    .busy(t_busy), .grant_ch(t_grant_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Full transfer from IDLE with done in the first WAIT_DONE cycle.
  task automatic do_xfer(input int ch, input logic [23:0] word);
    tick();
    chk("rr_start", 32'(send_start), 32'd1);
    chk("rr_grant", 32'(grant_ch), 32'(ch));
    chk("rr_data", 32'(send_data), 32'(word));
    tick();
    chk("rr_start_low", 32'(send_start), 32'd0);
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
    chk("rr_ack", 32'(ack), 32'(4'b0001 << ch));
    req[ch] = 1'b0;
    repeat (8) tick();
    chk("rr_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    unit_en = 1'b1;
    req_data = {24'hD3D3D3, 24'hC2C2C2, 24'hB1B1B1, 24'hA5A5A5};
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(send_start), 32'd0);
    chk("rst_data", 32'(send_data), 32'h0);
    chk("rst_grant", 32'(grant_ch), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rstn = 1'b1;

    // Single request, done 60 cycles after send_start
    req = 4'b0001;
    tick();
    chk("s_start", 32'(send_start), 32'd1);
    chk("s_data", 32'(send_data), 32'hA5A5A5);
    chk("s_busy", 32'(busy), 32'd1);
    tick();
    chk("s_start_pulse", 32'(send_start), 32'd0);
    repeat (59) tick();
    chk("s_no_ack_early", 32'(ack), 32'd0);
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
    req = 4'b0000;
    chk("s_ack", 32'(ack), 32'b0001);
    chk("s_err", 32'(err), 32'd0);
    tick();
    chk("s_ack_pulse", 32'(ack), 32'd0);
    chk("s_data_hold", 32'(send_data), 32'hA5A5A5);
    repeat (6) tick();
    chk("s_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("s_gap_end", 32'(busy), 32'd0);

    // Round robin 0,1,2,3 then requeued 0
    do_reset();
    req = 4'b1111;
    do_xfer(0, 24'hA5A5A5);
    do_xfer(1, 24'hB1B1B1);
    do_xfer(2, 24'hC2C2C2);
    do_xfer(3, 24'hD3D3D3);
    req = 4'b0001;
    do_xfer(0, 24'hA5A5A5);

    // Timeout on ch2 (dut_t, 16 cycles)
    do_reset();
    req = 4'b0100;
    tick();
    chk("t_grant", 32'(t_grant_ch), 32'd2);
    tick();
    repeat (15) tick();
    chk("t_no_err_early", 32'(t_err), 32'd0);
    chk("t_no_ack_early", 32'(t_ack), 32'd0);
    tick();
    chk("t_err", 32'(t_err), 32'b0100);
    chk("t_ack", 32'(t_ack), 32'b0100);
    req = 4'b0000;
    tick();
    chk("t_err_pulse", 32'(t_err), 32'd0);

    // Done coincides with timeout
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    repeat (15) tick();
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
    req = 4'b0000;
    chk("c_ack", 32'(t_ack), 32'b0100);
    chk("c_err", 32'(t_err), 32'd0);

    // Enable dropped mid-transfer, stray done in IDLE
    do_reset();
    req = 4'b0010;
    tick();
    chk("e_grant", 32'(grant_ch), 32'd1);
    tick();
    unit_en = 1'b0;
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
    chk("e_ack", 32'(ack), 32'b0010);
    req = 4'b0001;
    repeat (8) tick();
    chk("e_idle", 32'(busy), 32'd0);
    repeat (5) begin
      tick();
      chk("e_hold_start", 32'(send_start), 32'd0);
      chk("e_hold_busy", 32'(busy), 32'd0);
    end
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
    chk("stray_ack", 32'(ack), 32'd0);
    chk("stray_err", 32'(err), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    unit_en = 1'b1;
    tick();
    chk("e_resume_start", 32'(send_start), 32'd1);
    chk("e_resume_grant", 32'(grant_ch), 32'd0);

    // Reset during WAIT_DONE, then ch0 wins over ch3
    tick();
    req = 4'b1001;
    rstn = 1'b0;
    tick();
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ack", 32'(ack), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    chk("r_start", 32'(send_start), 32'd0);
    chk("r_grant", 32'(grant_ch), 32'd0);
    chk("r_data", 32'(send_data), 32'h0);
    rstn = 1'b1;
    tick();
    chk("r_first_start", 32'(send_start), 32'd1);
    chk("r_first_grant", 32'(grant_ch), 32'd0);
    chk("r_first_ack", 32'(ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msend_arbiter.md
MSEND_ARBITER -- requirements
Module: msend_arbiter

Interface
REQ-001 Parameters SHALL be: NCH, 4, number of requesting channels (fixed at 4 in this revision); GAP_CYC, 8, idle cycles between transfers (legal range 2..255); TMO_CYC, 1023, done-timeout in cycles (legal range 1..65535).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, synchronous active-low.
- unit_en  in  1  global enable; low blocks new grants.
- req  in  4  per-channel level request, held until that channel's ack.
- req_data  in  96  packed words, channel k in bits [24k+23:24k].
- ack  out  4  one-cycle completion pulse per channel.
- err  out  4  one-cycle timeout pulse per channel.
- send_start  out  1  start pulse to the 24-bit serializer.
- send_data  out  24  word to the serializer.
- sending  in  1  serializer busy status; informational only.
- send_done  in  1  serializer completion pulse.
- busy  out  1  high whenever state is not IDLE.
- grant_ch  out  2  channel currently or most recently granted.

Function
REQ-003 The arbiter SHALL use states IDLE, START, WAIT_DONE and GAP, all outputs registered or decoded from registered state.
REQ-004 IDLE: on an edge with unit_en=1 and req!=0, the arbiter SHALL latch the winning channel into grant_ch, latch its req_data word into send_data, and enter START; otherwise it SHALL remain in IDLE.
REQ-005 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps; the first asserted req wins.
REQ-006 After reset, last_grant SHALL be 3, so ch0 has first priority.
REQ-007 send_start SHALL be 1 for exactly the single cycle spent in START; START SHALL always advance to WAIT_DONE.
REQ-008 send_data SHALL hold its latched value from START until the next grant.
REQ-009 WAIT_DONE: a 16-bit timeout counter SHALL clear on entry and increment every cycle.
- send_done=1 SHALL cause a GAP entry with ack[grant_ch]=1 in the first GAP cycle.
- Counter reaching TMO_CYC-1 with send_done=0 SHALL cause a GAP entry with err[grant_ch]=1 and ack[grant_ch]=1 in the first GAP cycle.
REQ-010 If send_done and timeout coincide, done SHALL win: ack only, no err.
REQ-011 send_done outside WAIT_DONE SHALL be ignored.
REQ-012 GAP SHALL last exactly GAP_CYC cycles and then return to IDLE; req SHALL not be sampled during GAP.
REQ-013 Requesters SHALL drop req within one cycle of ack.
REQ-014 Latency from req sampled in IDLE to send_start high SHALL be 1 cycle.
REQ-015 unit_en falling mid-transfer SHALL NOT abort the transfer; the sequence completes through GAP, then the arbiter holds in IDLE.
REQ-016 At most one ack bit and one err bit SHALL be high in any cycle; no pulse SHALL be longer than one cycle.
REQ-017 req changes while not in IDLE SHALL have no effect on the current transfer.

Reset
REQ-018 With rstn=0 at a rising edge, the next-cycle state SHALL be: state IDLE; ack, err, send_start, busy and grant_ch all 0; send_data 24'h000000; timeout and gap counters 0; last_grant 3.
REQ-019 Reset asserted mid-transfer SHALL discard the transfer with no ack or err; resetting the serializer is the integrator's responsibility.

Verification
REQ-020 Bench scenarios:
- Single request: req=4'b0001, ch0 word 24'hA5A5A5; send_done 60 cycles after send_start -> send_start 1 cycle after req; send_data=24'hA5A5A5; ack=4'b0001 for one cycle; busy low after 8 GAP cycles.
- Round-robin: req=4'b1111 held, each requester drops on its ack -> grant order 0,1,2,3; requeued ch0 after ch3 gives 0 again.
- Timeout: TMO_CYC=16, send_done never asserted -> err=ack=4'b0100 for ch2 exactly 16 cycles after WAIT_DONE entry.
- Coincidence: send_done on the timeout cycle -> ack only, err stays 0.
- Enable and stray done: unit_en dropped during WAIT_DONE -> transfer completes, no further send_start while unit_en=0; send_done pulse in IDLE causes no output change.
- Reset mid-WAIT_DONE: rstn=0 for one cycle -> all REQ-018 values next cycle, no ack; first grant after reset goes to ch0.
